// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding and operation codes.
package addsub_serial_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_digit.sv
// DIGIT-bit ripple slice built from fulladder cells; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_s[i]),
      .s  (s[i]),
      .co (c_s[i+1])
    );
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder, the basic cell of the ripple slices.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor, DIGIT bits per cycle, LSB first, with a
// ready/valid handshake on both sides. Define ADDSUB_SERIAL_SAT_EN to make
// sum saturate on signed overflow.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             overflow_r;
  logic             carry_out_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout_s;
  logic             dig_cmsb_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             ovf_nxt_s;
  logic [WIDTH-1:0] result_s;

  assign accept_s = in_valid && in_ready_r;
  assign last_s   = (cnt_r == CW'(NDIG - 1));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh_r[DIGIT-1:0]),
    .b    (b_sh_r[DIGIT-1:0]),
    .cin  (carry_r),
    .s    (dig_s),
    .cout (dig_cout_s),
    .cmsb (dig_cmsb_s)
  );

  // New digits enter at the top so the final shift leaves the result aligned.
  assign acc_nxt_s = (acc_r >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign ovf_nxt_s = dig_cmsb_s ^ dig_cout_s;

`ifdef ADDSUB_SERIAL_SAT_EN
  logic             a_msb_r;
  logic [WIDTH-1:0] sat_val_s;

  assign sat_val_s = a_msb_r ? (WIDTH'(1) << (WIDTH - 1)) : ~(WIDTH'(1) << (WIDTH - 1));

  // Clamp toward the sign of A when the signed result wraps.
  always_comb begin
    if (ovf_nxt_s) begin
      result_s = sat_val_s;
    end else begin
      result_s = acc_nxt_s;
    end
  end

  // Capture A's sign at accept for the saturation direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_r <= 1'b0;
    end else if (accept_s) begin
      a_msb_r <= a[WIDTH-1];
    end else begin
      a_msb_r <= a_msb_r;
    end
  end
`else
  assign result_s = acc_nxt_s;
`endif

  // Next-state logic for the IDLE/BUSY/DONE handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand shifters, ripple carry and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      acc_r       <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      overflow_r  <= 1'b0;
      carry_out_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sh_r <= a;
            acc_r  <= '0;
            cnt_r  <= '0;
            case (sub)
              OP_ADD: begin
                b_sh_r  <= b;
                carry_r <= 1'b0;
              end
              OP_SUB: begin
                b_sh_r  <= ~b;
                carry_r <= 1'b1;
              end
              default: begin
                b_sh_r  <= b;
                carry_r <= 1'b0;
              end
            endcase
          end
        end
        ST_BUSY: begin
          a_sh_r  <= a_sh_r >> DIGIT;
          b_sh_r  <= b_sh_r >> DIGIT;
          acc_r   <= acc_nxt_s;
          carry_r <= dig_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r       <= result_s;
            overflow_r  <= ovf_nxt_s;
            carry_out_r <= dig_cout_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign overflow  = overflow_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: WIDTH=6/DIGIT=2 main instance plus a
// WIDTH=8/DIGIT=8 instance for the single-cycle case.
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sub, out_valid, out_ready, overflow, carry_out;
  logic [5:0] a, b, sum;

  logic       w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_overflow, w_carry_out;
  logic [7:0] w_a, w_b, w_sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(6), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .carry_out(carry_out)
  );

  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .overflow(w_overflow), .carry_out(w_carry_out)
  );

  // Accept one operation on the main instance, then scramble inputs and
  // count rising edges until out_valid is seen (bounded).
  task automatic run_op(input logic [5:0] av, input logic [5:0] bv, input logic sv,
                        output int lat);
    @(negedge clk);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 6'h2A; b = 6'h15; sub = ~sv;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, sum, overflow, carry_out} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%0d ovf=%b co=%b, want 1 0 0 0 0",
               in_ready, out_valid, sum, overflow, carry_out);
    end
    vectors++;
    if ({w_in_ready, w_out_valid, w_sum} !== {1'b1, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_wide: got rdy=%b vld=%b sum=%0d, want 1 0 0", w_in_ready, w_out_valid, w_sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input logic [5:0] av, input logic [5:0] bv,
                         input logic sv, input logic [5:0] esum, input logic eovf, input logic eco);
    int lat;
    run_op(av, bv, sv, lat);
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, want 3", name, lat);
    end
    vectors++;
    if ({sum, overflow, carry_out, in_ready} !== {esum, eovf, eco, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got sum=%0d ovf=%b co=%b rdy=%b, want sum=%0d ovf=%b co=%b rdy=0",
               name, sum, overflow, carry_out, in_ready, esum, eovf, eco);
    end
    consume();
  endtask

  task automatic test_add();
    test_op("add_5_3", 6'd5, 6'd3, 1'b0, 6'd8, 1'b0, 1'b0);
    test_op("add_63_1", 6'd63, 6'd1, 1'b0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic test_add_overflow();
`ifdef ADDSUB_SERIAL_SAT_EN
    test_op("add_ovf", 6'd31, 6'd1, 1'b0, 6'd31, 1'b1, 1'b0);
`else
    test_op("add_ovf", 6'd31, 6'd1, 1'b0, 6'd32, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_sub();
`ifdef ADDSUB_SERIAL_SAT_EN
    test_op("sub_ovf", 6'd32, 6'd1, 1'b1, 6'd32, 1'b1, 1'b1);
`else
    test_op("sub_ovf", 6'd32, 6'd1, 1'b1, 6'd31, 1'b1, 1'b1);
`endif
    test_op("sub_3_5", 6'd3, 6'd5, 1'b1, 6'd62, 1'b0, 1'b0);
    test_op("sub_9_9", 6'd9, 6'd9, 1'b1, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    run_op(6'd10, 6'd7, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, sum, overflow, carry_out} !== {1'b1, 1'b0, 6'd17, 1'b0, 1'b0}) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0 (last sum=%0d)", bad, sum);
    end
    // Offer the next op in the same cycle the result is consumed.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 6'd4; b = 6'd2; sub = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL consume_cycle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL next_accept: got rdy=%b, want 0", in_ready);
    end
    lat = 0;
    while (lat < 20 && !out_valid) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    vectors++;
    if ({lat, sum} !== {32'd3, 6'd2}) begin
      miscompares++;
      $display("FAIL back_to_back: got lat=%0d sum=%0d, want lat=3 sum=2", lat, sum);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a = 6'd63; b = 6'd0; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum, overflow, carry_out} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_busy: got rdy=%b vld=%b sum=%0d ovf=%b co=%b, want 1 0 0 0 0",
               in_ready, out_valid, sum, overflow, carry_out);
    end
    repeat (4) begin
      @(negedge clk);
      if (out_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL reset_abandon: got out_valid=1, want 0");
      end
    end
    test_op("after_reset", 6'd1, 6'd1, 1'b0, 6'd2, 1'b0, 1'b0);
  endtask

  task automatic test_wide();
    int lat = 0;
    @(negedge clk);
    w_a = 8'd127; w_b = 8'd1; w_sub = 1'b0; w_in_valid = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0; w_a = 8'd0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (w_out_valid) break;
    end
    vectors++;
    if ({lat, w_sum, w_overflow, w_carry_out} !==
`ifdef ADDSUB_SERIAL_SAT_EN
        {32'd1, 8'd127, 1'b1, 1'b0}) begin
`else
        {32'd1, 8'd128, 1'b1, 1'b0}) begin
`endif
      miscompares++;
      $display("FAIL wide_single_digit: got lat=%0d sum=%0d ovf=%b co=%b", lat, w_sum, w_overflow, w_carry_out);
    end
    @(negedge clk);
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0;
    test_reset();
    test_add();
    test_add_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, operand and result width in bits (>= 2).
REQ-002 The block SHALL have parameter DIGIT, default 2, bits processed per cycle; WIDTH % DIGIT == 0 is required.
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  operands and op are valid.
REQ-006 Port in_ready  output  1  the block can accept an operation.
REQ-007 Port a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 Port out_valid  output  1  result is valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port sum  output  WIDTH  result.
REQ-013 Port overflow  output  1  signed overflow of the operation.
REQ-014 Port carry_out  output  1  carry out of MSB; for sub, 1 = no borrow.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE->BUSY SHALL occur on in_valid && in_ready; a, b and sub are registered on that edge, and later input changes are ignored.
REQ-018 On accept, the block SHALL register B as b (sub=0) or ~b (sub=1); the carry register SHALL be 0 (sub=0) or 1 (sub=1).
REQ-019 Each BUSY cycle SHALL add the next DIGIT-bit slice, LSB first, with the ripple carry held in a register between cycles.
REQ-020 BUSY SHALL last exactly WIDTH/DIGIT cycles; out_valid SHALL rise WIDTH/DIGIT cycles after the accepting edge.
REQ-021 Definitions: overflow = carry into MSB XOR carry out of MSB; carry_out = carry out of MSB.
REQ-022 DONE->IDLE SHALL occur on out_ready; while out_ready=0, sum, overflow and carry_out SHALL hold stable.
REQ-023 No new operation SHALL be accepted in the cycle the result is consumed; the earliest next accept is the following cycle.
REQ-024 When WIDTH == DIGIT, BUSY SHALL last one cycle.
REQ-025 Outside DONE, sum, overflow and carry_out SHALL hold their last values.

Reset
REQ-026 rst=1 SHALL force IDLE, and sum=0, overflow=0, carry_out=0, out_valid=0, in_ready=1 on the next edge.
REQ-027 rst in BUSY or DONE SHALL abandon the operation with no result delivered, and SHALL take priority over every handshake.

Configuration
REQ-028 With macro ADDSUB_SERIAL_SAT_EN defined, sum SHALL saturate on overflow=1: to 0111..1 if the registered A MSB=0, or to 1000..0 if it is 1. overflow still reports 1.
REQ-029 Without ADDSUB_SERIAL_SAT_EN, sum SHALL be the raw wrapped result and no saturation logic shall exist.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1, DONE=2) and the op constants OP_ADD=0 and OP_SUB=1.
REQ-031 One sub-module, addsub_digit, SHALL implement a DIGIT-bit ripple slice built from the existing fulladder. Outputs: DIGIT sum bits, carry out, and carry into its MSB.

Verification (WIDTH=6, DIGIT=2 unless stated)
REQ-032 Add: a=5, b=3, sub=0 -> out_valid 3 cycles after accept; sum=8, overflow=0, carry_out=0.
REQ-033 Add overflow: a=31, b=1 -> sum=32 (100000b), overflow=1. With SAT_EN -> sum=31.
REQ-034 Sub: a=32 (-32), b=1, sub=1 -> sum=31, overflow=1, carry_out=1. With SAT_EN -> sum=32. Sub a=3, b=5 -> sum=62, overflow=0, carry_out=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; release -> IDLE, and the next accept takes one cycle later.
REQ-036 Reset: assert rst in the 2nd BUSY cycle -> next edge IDLE, all outputs 0; a following a=1, b=1 gives sum=2 with no stale carry.
REQ-037 WIDTH=8, DIGIT=8 -> a=127, b=1 gives sum=128, overflow=1 after 1 BUSY cycle.
